// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count monitor / 7-segment display slice.
// Optional step checking is enabled by defining STEP_CHECK_EN.
package count_mon_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned CNT_N_DEF = 16;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] digit);
    return HEX_SEG[digit];
  endfunction

endpackage

// File: rtl/count_seg_display_if.sv
// Bundle between the upstream counter/controls and the display monitor.
interface count_seg_display_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
);
  import count_mon_pkg::*;

  logic [WIDTH-1:0]  count_in;
  logic              hold;
  logic              clr_err;
  logic [SEG_W-1:0]  seg_n;
  logic              disp_valid;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              step_err;

  modport master (
    output count_in, hold, clr_err,
    input  seg_n, disp_valid, wrap_pulse, wrap_cnt, step_err
  );

  modport slave (
    input  count_in, hold, clr_err,
    output seg_n, disp_valid, wrap_pulse, wrap_cnt, step_err
  );

endinterface

// File: rtl/count_seg_display_hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg7
  import count_mon_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_n_c
);

  assign seg_n_c = hex7(digit);

endmodule

// File: rtl/count_seg_display.sv
// Monitors an up-counter: registered hex display, wrap pulse/count, sticky step error.
// Step checking and the ERROR state exist only when STEP_CHECK_EN is defined.
module count_seg_display
  import count_mon_pkg::*;
#(
  parameter int unsigned COUNTER_NUMBER = CNT_N_DEF,
  parameter int unsigned WIDTH          = CNT_W_DEF,
  parameter int unsigned WRAP_W         = WRAP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  count_seg_display_if.slave bus
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic [SEG_W-1:0]  digit_seg_c;
  logic              wrap_c;
  logic              step_ok_c;

  hex_to_seg7 u_dec (
    .digit   (4'(bus.count_in)),
    .seg_n_c (digit_seg_c)
  );

  // A wrap is only ever the exact N-1 -> 0 step, with or without checking
  assign wrap_c = (prev_q == WIDTH'(COUNTER_NUMBER - 1)) && (bus.count_in == '0);

`ifdef STEP_CHECK_EN
  logic in_range_c;
  logic inc_c;
  assign in_range_c = 32'(bus.count_in) < COUNTER_NUMBER;
  assign inc_c      = (bus.count_in == prev_q + WIDTH'(1)) &&
                      ((32'(prev_q) + 32'd1) < COUNTER_NUMBER);
  assign step_ok_c  = in_range_c && ((bus.count_in == prev_q) || inc_c || wrap_c);
`else
  assign step_ok_c  = 1'b1;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    seg_d   = seg_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_INIT: begin
        prev_d  = bus.count_in;
        valid_d = 1'b1;
        state_d = ST_TRACK;
        if (!bus.hold) seg_d = digit_seg_c;
      end
      ST_TRACK: begin
        prev_d = bus.count_in;
        if (step_ok_c) begin
          if (!bus.hold) seg_d = digit_seg_c;
          if (wrap_c) begin
            pulse_d = 1'b1;
            wcnt_d  = wcnt_q + WRAP_W'(1);
          end
        end else begin
          err_d   = 1'b1;
          seg_d   = SEG_E;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        seg_d = SEG_E;
        if (bus.clr_err) begin
          err_d   = 1'b0;
          valid_d = 1'b0;
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      prev_q  <= '0;
      seg_q   <= SEG_BLANK;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      seg_q   <= seg_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.disp_valid = valid_q;
  assign bus.wrap_pulse = pulse_q;
  assign bus.wrap_cnt   = wcnt_q;
  assign bus.step_err   = err_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Randomized self-checking bench for count_seg_display against a cycle-level behavioural model.
module tb_count_seg_display;

  localparam int N = 16;

`ifdef STEP_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_seg_display_if #(.WIDTH(4), .WRAP_W(8)) bus ();

  count_seg_display #(.COUNTER_NUMBER(16), .WIDTH(4), .WRAP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [17:0] RESET_VEC = {7'h7F, 1'b0, 1'b0, 8'h00, 1'b0};

  int checks = 0;
  int errors = 0;

  // Behavioural model: m_ref = a reference sample is held, m_err = sticky error
  bit         m_ref, m_err, m_pulse;
  int         m_prev, m_wcnt;
  logic [6:0] m_seg;

  function automatic void model_reset();
    m_ref = 0; m_err = 0; m_pulse = 0; m_prev = 0; m_wcnt = 0; m_seg = 7'h7F;
  endfunction

  function automatic void model_upd(int c, bit h, bit clr);
    bit wrap, legal;
    m_pulse = 0;
    if (m_err) begin
      m_seg = 7'h06;
      if (clr) begin m_err = 0; m_ref = 0; end
    end else if (!m_ref) begin
      m_ref = 1; m_prev = c;
      if (!h) m_seg = seg_ref[c];
    end else begin
      wrap  = (m_prev == N - 1) && (c == 0);
      legal = !CHECK || (c < N && (c == m_prev || c == m_prev + 1 || wrap));
      if (legal) begin
        if (!h) m_seg = seg_ref[c];
        if (wrap) begin m_pulse = 1; m_wcnt = (m_wcnt + 1) % 256; end
      end else begin
        m_err = 1; m_seg = 7'h06;
      end
      m_prev = c;
    end
  endfunction

  function automatic logic [17:0] obs();
    return {bus.seg_n, bus.disp_valid, bus.wrap_pulse, bus.wrap_cnt, bus.step_err};
  endfunction

  function automatic logic [17:0] exp_v();
    return {m_seg, m_ref, m_pulse, 8'(m_wcnt), m_err};
  endfunction

  task automatic tick(input int c, input bit h, input bit clr);
    @(negedge clk);
    bus.count_in = 4'(c);
    bus.hold     = h;
    bus.clr_err  = clr;
    @(posedge clk);
    #1;
    model_upd(c, h, clr);
  endtask

  task automatic goto_count(input int t);
    while (m_prev != t || !m_ref) tick((m_prev + 1) % N, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.count_in = '0; bus.hold = 1'b0; bus.clr_err = 1'b0;
    model_reset();
    #12;
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL reset_values got %h exp %h", obs(), RESET_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_count_seq();
    int pulses = 0;
    for (int i = 0; i <= 16; i++) begin
      tick(i % N, 1'b0, 1'b0);
      pulses += int'(bus.wrap_pulse);
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL count_seq i=%0d got %h exp %h", i, obs(), exp_v());
      end
    end
    checks++;
    if (pulses != 1 || bus.wrap_cnt !== 8'd1) begin
      errors++; $display("FAIL count_seq_wrap pulses=%0d cnt=%0d exp 1/1", pulses, bus.wrap_cnt);
    end
  endtask

  task automatic test_wrap_256();
    int pulses = 0;
    int start = m_wcnt;
    for (int w = 0; w < 256; w++) begin
      for (int c = 1; c <= N; c++) begin
        tick(c % N, 1'b0, 1'b0);
        pulses += int'(bus.wrap_pulse);
        checks++;
        if (obs() !== exp_v()) begin
          errors++; $display("FAIL wrap_256 w=%0d c=%0d got %h exp %h", w, c, obs(), exp_v());
        end
      end
    end
    checks++;
    if (pulses != 256 || int'(bus.wrap_cnt) != start) begin
      errors++; $display("FAIL wrap_256_total pulses=%0d cnt=%0d exp 256/%0d", pulses, bus.wrap_cnt, start);
    end
  endtask

  task automatic test_hold();
    int c;
    goto_count(4);
    tick(5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c = ($urandom % 2 == 0) ? m_prev : m_prev + 1;
      tick(c, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_v() || bus.seg_n !== 7'h12) begin
        errors++; $display("FAIL hold_5 i=%0d got %h exp %h", i, obs(), exp_v());
      end
    end
    goto_count(15);
    tick(0, 1'b1, 1'b0);
    checks++;
    if (obs() !== exp_v() || bus.wrap_pulse !== 1'b1 || bus.seg_n !== 7'h0E) begin
      errors++; $display("FAIL hold_wrap got %h exp %h", obs(), exp_v());
    end
    tick(1, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_v()) begin
      errors++; $display("FAIL hold_release got %h exp %h", obs(), exp_v());
    end
  endtask

  task automatic test_stall();
    int seq [4] = '{4, 4, 4, 5};
    goto_count(3);
    foreach (seq[i]) begin
      tick(seq[i], 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_v() || bus.step_err !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL stall i=%0d got %h exp %h", i, obs(), exp_v());
      end
    end
    tick(6, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp_v() || bus.disp_valid !== 1'b1) begin
      errors++; $display("FAIL clr_in_track got %h exp %h", obs(), exp_v());
    end
  endtask

  task automatic test_step_err();
    int c;
    goto_count(3);
`ifdef STEP_CHECK_EN
    tick(7, 1'b1, 1'b0);
    checks++;
    if (obs() !== exp_v() || bus.step_err !== 1'b1 || bus.seg_n !== 7'h06) begin
      errors++; $display("FAIL step_err_set got %h exp %h", obs(), exp_v());
    end
    for (int i = 0; i < 10; i++) begin
      c = (i == 8) ? 15 : (i == 9) ? 0 : int'($urandom % N);
      tick(c, 1'($urandom % 2), 1'b0);
      checks++;
      if (obs() !== exp_v() || bus.wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL err_frozen i=%0d got %h exp %h", i, obs(), exp_v());
      end
    end
    c = int'($urandom % N);
    tick(c, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp_v() || bus.disp_valid !== 1'b0 || bus.step_err !== 1'b0) begin
      errors++; $display("FAIL clr_err got %h exp %h", obs(), exp_v());
    end
    tick(c, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_v() || bus.disp_valid !== 1'b1 || bus.seg_n !== seg_ref[c]) begin
      errors++; $display("FAIL reinit got %h exp %h", obs(), exp_v());
    end
    tick((c + 1) % N, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_v()) begin
      errors++; $display("FAIL resume got %h exp %h", obs(), exp_v());
    end
`else
    tick(7, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_v() || bus.step_err !== 1'b0 || bus.seg_n !== 7'h78) begin
      errors++; $display("FAIL no_check_jump got %h exp %h", obs(), exp_v());
    end
    tick(8, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp_v() || bus.disp_valid !== 1'b1) begin
      errors++; $display("FAIL no_check_clr got %h exp %h", obs(), exp_v());
    end
`endif
  endtask

  task automatic test_random();
    int r, c;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom % 16);
      clr = 1'b0;
      if (r < 4)       c = m_prev;
      else if (r == 4) c = int'($urandom % N);
      else             c = (m_prev + 1) % N;
      if (m_err && ($urandom % 4 == 0)) clr = 1'b1;
      tick(c, 1'($urandom % 3 == 0), clr);
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL random i=%0d got %h exp %h", i, obs(), exp_v());
      end
    end
    if (m_err) tick(0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    tick(0, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++)
      for (int c = 1; c <= N; c++) tick(c % N, 1'b0, 1'b0);
    tick(1, 1'b0, 1'b0);
    checks++;
    if (bus.wrap_cnt !== 8'd3 || obs() !== exp_v()) begin
      errors++; $display("FAIL pre_reset cnt=%0d got %h exp %h", bus.wrap_cnt, obs(), exp_v());
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs(), RESET_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
    tick(9, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_v()) begin
      errors++; $display("FAIL post_reset got %h exp %h", obs(), exp_v());
    end
  endtask

  initial begin
    test_reset();
    test_count_seq();
    test_wrap_256();
    test_hold();
    test_stall();
    test_step_err();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
